// File: rtl/modinv_pkg.sv
// Shared definitions for the modular inverter: FSM state type and default width.
package modinv_pkg;

    localparam int unsigned MODINV_N_DEFAULT = 231;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } modinv_state_e;

endpackage

// File: rtl/modinv_halfsub.sv
// Combinational helpers for the binary extended Euclid coefficient updates:
//   half(a)      = (a + (a odd ? p : 0)) >> 1, computed on n+1 bits
//   submod(a, b) = a >= b ? a - b : a - b + p
module modinv_halfsub #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic [n-1:0] i_p,
    output logic [n-1:0] o_half,
    output logic [n-1:0] o_sub
);

    logic [n:0] w_half_sum;

    // Halve modulo p and subtract modulo p; the n-bit wrap of a - b + p is exact for a, b < p.
    always_comb begin
        w_half_sum = {1'b0, i_a} + (i_a[0] ? {1'b0, i_p} : {(n+1){1'b0}});
        o_half     = w_half_sum[n:1];
        if (i_a >= i_b) begin
            o_sub = i_a - i_b;
        end else begin
            o_sub = i_a - i_b + i_p;
        end
    end

endmodule

// File: rtl/modular_inverter.sv
// Modular inverter: computes R = A^-1 mod p (p odd) with the binary extended Euclid
// algorithm, one reduction step per cycle. Flag pulses for one cycle in DONE; err marks
// illegal input or a non-invertible operand.
// Optional feature: define MODINV_CYCLE_COUNT_EN to add the 'cycles' output (RUN-cycle count).
module modular_inverter
    import modinv_pkg::*;
#(
    parameter int unsigned n = MODINV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] p,
    output logic [n-1:0] R,
    output logic         flag,
    output logic         err,
`ifdef MODINV_CYCLE_COUNT_EN
    output logic [n-1:0] cycles,
`endif
    output logic         busy
);

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    modinv_state_e r_state, w_state_d;
    logic [n-1:0]  r_u, r_v, r_x1, r_x2, r_p, r_R;
    logic [n-1:0]  w_u_d, w_v_d, w_x1_d, w_x2_d, w_p_d, w_R_d;
    logic          r_err, w_err_d;
    logic [n-1:0]  w_x1_half, w_x1_sub, w_x2_half, w_x2_sub;

    modinv_halfsub #(.n(n)) u_hs_x1 (
        .i_a    (r_x1),
        .i_b    (r_x2),
        .i_p    (r_p),
        .o_half (w_x1_half),
        .o_sub  (w_x1_sub)
    );

    modinv_halfsub #(.n(n)) u_hs_x2 (
        .i_a    (r_x2),
        .i_b    (r_x1),
        .i_p    (r_p),
        .o_half (w_x2_half),
        .o_sub  (w_x2_sub)
    );

    // Next-state and datapath update: capture on start, one Euclid step or termination per RUN cycle.
    always_comb begin
        w_state_d = r_state;
        w_u_d     = r_u;
        w_v_d     = r_v;
        w_x1_d    = r_x1;
        w_x2_d    = r_x2;
        w_p_d     = r_p;
        w_R_d     = r_R;
        w_err_d   = r_err;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_u_d  = A;
                    w_v_d  = p;
                    w_x1_d = ONE;
                    w_x2_d = '0;
                    w_p_d  = p;
                    if ((A == '0) || (A >= p) || !p[0]) begin
                        w_state_d = DONE;
                        w_err_d   = 1'b1;
                        w_R_d     = '0;
                    end else begin
                        w_state_d = RUN;
                    end
                end
            end
            RUN: begin
                if ((r_u == '0) || (r_v == '0)) begin
                    // gcd(A, p) > 1: the common factor drove one side to zero
                    w_state_d = DONE;
                    w_err_d   = 1'b1;
                    w_R_d     = '0;
                end else if (r_u == ONE) begin
                    w_state_d = DONE;
                    w_err_d   = 1'b0;
                    w_R_d     = r_x1;
                end else if (r_v == ONE) begin
                    w_state_d = DONE;
                    w_err_d   = 1'b0;
                    w_R_d     = r_x2;
                end else if (!r_u[0]) begin
                    w_u_d  = r_u >> 1;
                    w_x1_d = w_x1_half;
                end else if (!r_v[0]) begin
                    w_v_d  = r_v >> 1;
                    w_x2_d = w_x2_half;
                end else if (r_u >= r_v) begin
                    w_u_d  = r_u - r_v;
                    w_x1_d = w_x1_sub;
                end else begin
                    w_v_d  = r_v - r_u;
                    w_x2_d = w_x2_sub;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_u     <= '0;
            r_v     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_p     <= '0;
            r_R     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_u     <= w_u_d;
            r_v     <= w_v_d;
            r_x1    <= w_x1_d;
            r_x2    <= w_x2_d;
            r_p     <= w_p_d;
            r_R     <= w_R_d;
            r_err   <= w_err_d;
        end
    end

`ifdef MODINV_CYCLE_COUNT_EN
    logic [n-1:0] r_cycles;

    // Count RUN cycles of the current operation; cleared on an accepted start, frozen afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_cycles <= '0;
        end else if (r_state == RUN) begin
            r_cycles <= r_cycles + ONE;
        end
    end

    assign cycles = r_cycles;
`endif

    assign R    = r_R;
    assign err  = r_err;
    assign flag = (r_state == DONE);
    assign busy = (r_state == RUN);

endmodule

// File: doc/modular_inverter.md
MODULAR_INVERTER -- requirements
Module: modular_inverter

Interface
- REQ-001 SHALL have parameter n, default 231, giving the operand, modulus and result width in bits.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL have port start, input, 1 bit: request an inversion; sampled only in IDLE.
- REQ-005 SHALL have port A, input, n bits: the operand, captured on the accepted start.
- REQ-006 SHALL have port p, input, n bits: the modulus (odd), captured on the accepted start.
- REQ-007 SHALL have port R, output, n bits: the result A^-1 mod p, held until the next accepted start.
- REQ-008 SHALL have port flag, output, 1 bit: a one-cycle pulse when R and err are valid.
- REQ-009 SHALL have port err, output, 1 bit: no inverse exists or the input is illegal; valid with flag and held with R.
- REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.

Function
- REQ-011 SHALL implement the FSM IDLE -> RUN (start=1) -> DONE (termination) -> IDLE (unconditionally, after one cycle).
- REQ-012 SHALL, on an accepted start, load u=A, v=p, x1=1, x2=0 and enter RUN at the same edge.
- REQ-013 SHALL ignore start while in RUN or DONE; no queuing.
- REQ-014 SHALL, on an accepted start with A==0, A>=p or p even, skip RUN and enter DONE with err=1 and R=0.
- REQ-015 SHALL evaluate each RUN cycle in this priority order:
  - u==0 or v==0: DONE, err=1, R=0.
  - u==1: DONE, R=x1.
  - v==1: DONE, R=x2.
  - otherwise: exactly one step (REQ-016).
- REQ-016 SHALL perform the step as follows:
  - u even: u=u>>1, x1=half(x1).
  - else v even: v=v>>1, x2=half(x2).
  - else u>=v: u=u-v, x1=submod(x1,x2).
  - else: v=v-u, x2=submod(x2,x1).
- REQ-017 SHALL compute half(x) = (x + (x odd ? p : 0)) >> 1 using an n+1-bit intermediate, with no overflow loss.
- REQ-018 SHALL compute submod(a,b) = a>=b ? a-b : a-b+p; the result is always in [0,p-1].
- REQ-019 SHALL terminate within 4n+2 cycles of an accepted start for any legal input.
- REQ-020 SHALL assert flag only in DONE, for exactly one cycle; R and err update on the edge entering DONE.
- REQ-021 SHALL make a minimum latency of 2 cycles from the start edge to flag high (e.g. A=1).
- REQ-022 SHALL keep A and p used internally stable after capture; input changes during RUN have no effect.

Reset
- REQ-023 SHALL, when reset is asserted at any time (including mid-RUN), immediately force IDLE, R=0, flag=0, err=0, busy=0, u=v=x1=x2=0.
- REQ-024 SHALL, after reset release, accept a start on the first clock edge.

Configuration
- REQ-025 SHALL, with MODINV_CYCLE_COUNT_EN defined, add output port cycles (n bits): RUN-cycle count of the last operation, cleared on accepted start, held from DONE.
- REQ-026 SHALL, without MODINV_CYCLE_COUNT_EN, have no cycles port or counter logic; all other behaviour is identical.

Structure
- REQ-027 SHALL place the FSM state enum (IDLE, RUN, DONE) and the default width constant in shared package modinv_pkg.
- REQ-028 SHALL implement half() and submod() in one combinational sub-module modinv_halfsub (parameter n), instantiated twice (x1 path, x2 path).

Verification (bench with n=8 unless stated)
- REQ-029 SHALL cover: A=3, p=7, start -> flag within 34 cycles, R=5, err=0.
- REQ-030 SHALL cover: A=1, p=251 -> flag exactly 2 cycles after start, R=1; and A=250, p=251 -> R=250.
- REQ-031 SHALL cover illegal inputs:
  - A=0, p=7 -> err=1, R=0.
  - A=9, p=7 -> err=1, R=0.
  - A=3, p=8 -> err=1, R=0.
  - A=5, p=15 (gcd 5) -> err=1, R=0.
  - All of these complete within 34 cycles.
- REQ-032 SHALL cover: start A=3, p=7; pulse start with A=2 at cycle 3 -> ignored, R=5; then a new start A=2, p=7 -> R=4.
- REQ-033 SHALL cover: assert reset mid-RUN -> same cycle R=0, busy=0, flag=0; next start A=4, p=7 -> R=2.
- REQ-034 SHALL cover, at n=231: 1000 random odd prime p and random A in [1,p-1] -> R*A mod p == 1, each within 4n+2 cycles.
